// File: rtl/pl_reset_pkg.sv
// Shared types and constants for the staged PL reset sequencer.
// Counter widths, default parameters, sequencer state encoding.
package pl_reset_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEB_W = 4;
  localparam int unsigned IDX_W = 3;

  localparam int unsigned DEF_NUM_PERIPH      = 4;
  localparam int unsigned DEF_HOLD_CYCLES     = 16;
  localparam int unsigned DEF_STAGE_GAP       = 8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    REL_IC     = 2'd1,
    REL_PERIPH = 2'd2,
    RUN        = 2'd3
  } seq_state_e;

  // Saturating increment for event counters
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pl_reset_if.sv
// Reset request/response bundle between the sequencer (master) and the
// reset consumers / request sources (slave).
interface pl_reset_if
  import pl_reset_pkg::*;
#(
  parameter int unsigned NUM_PERIPH = DEF_NUM_PERIPH
);

  logic                  aux_reset_in;
  logic [NUM_PERIPH-1:0] periph_sw_reset;
  logic                  interconnect_aresetn;
  logic [NUM_PERIPH-1:0] peripheral_aresetn;
  logic [NUM_PERIPH-1:0] peripheral_reset;
  logic                  reset_done;
  logic [CNT_W-1:0]      reset_count;

  modport master (
    input  aux_reset_in,
    input  periph_sw_reset,
    output interconnect_aresetn,
    output peripheral_aresetn,
    output peripheral_reset,
    output reset_done,
    output reset_count
  );

  modport slave (
    output aux_reset_in,
    output periph_sw_reset,
    input  interconnect_aresetn,
    input  peripheral_aresetn,
    input  peripheral_reset,
    input  reset_done,
    input  reset_count
  );

endinterface

// File: rtl/pl_reset_hold_timer.sv
// Per-channel software reset hold timer: stays active for HOLD_CYCLES edges
// after the last start; clear wins over start.
module pl_reset_hold_timer
  import pl_reset_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic active,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt;

  // Last edge of the hold window
  assign expire_c = active && (cnt == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (expire_c) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pl_reset_sequencer.sv
// Staged PL reset controller: interconnect first, then peripherals one per
// STAGE_GAP, with debounced aux global reset and per-channel software resets.
module pl_reset_sequencer
  import pl_reset_pkg::*;
#(
  parameter int unsigned NUM_PERIPH      = DEF_NUM_PERIPH,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned STAGE_GAP       = DEF_STAGE_GAP,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       slowest_sync_clk,
  input  logic       ext_reset_in,
  pl_reset_if.master rst_bus
);

  seq_state_e            state;
  logic [CNT_W-1:0]      hold_cnt;
  logic [CNT_W-1:0]      gap_cnt;
  logic [CNT_W-1:0]      reset_count_q;
  logic [DEB_W-1:0]      deb_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  ic_n_q;
  logic                  done_q;
  logic [NUM_PERIPH-1:0] periph_n_q;
  logic [NUM_PERIPH-1:0] periph_q;
  logic [NUM_PERIPH-1:0] rel_bit;
  logic [NUM_PERIPH-1:0] sw_start;
  logic [NUM_PERIPH-1:0] sw_active;
  logic [NUM_PERIPH-1:0] sw_expire;
  logic [NUM_PERIPH-1:0] sw_hold_nxt;
  logic                  sw_clear;
  logic                  aux_trig;

  // Final debounced sample of an aux request outside ASSERT
  assign aux_trig = (state != ASSERT) && rst_bus.aux_reset_in &&
                    (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));

  assign sw_clear    = aux_trig || (state != RUN);
  assign sw_start    = (state == RUN) ? rst_bus.periph_sw_reset : '0;
  assign sw_hold_nxt = sw_start | (sw_active & ~sw_expire);
  assign rel_bit     = NUM_PERIPH'(1) << idx;

  for (genvar i = 0; i < NUM_PERIPH; i++) begin : g_hold
    pl_reset_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
      .clk      (slowest_sync_clk),
      .rst_n    (ext_reset_in),
      .start    (sw_start[i]),
      .clear    (sw_clear),
      .active   (sw_active[i]),
      .expire_c (sw_expire[i])
    );
  end

  always_ff @(posedge slowest_sync_clk) begin
    if (!ext_reset_in) begin
      state         <= ASSERT;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      deb_cnt       <= '0;
      idx           <= '0;
      ic_n_q        <= 1'b0;
      periph_n_q    <= '0;
      periph_q      <= '1;
      done_q        <= 1'b0;
      reset_count_q <= '0;
    end else if (aux_trig) begin
      state         <= ASSERT;
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      deb_cnt       <= '0;
      idx           <= '0;
      ic_n_q        <= 1'b0;
      periph_n_q    <= '0;
      periph_q      <= '1;
      done_q        <= 1'b0;
      reset_count_q <= sat_inc(reset_count_q);
    end else begin
      // Debounce only runs once the sequence has left ASSERT
      if ((state != ASSERT) && rst_bus.aux_reset_in) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end else begin
        deb_cnt <= '0;
      end

      case (state)
        ASSERT: begin
          if (rst_bus.aux_reset_in) begin
            hold_cnt <= '0;
          end else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            ic_n_q   <= 1'b1;
            state    <= REL_IC;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        REL_IC, REL_PERIPH: begin
          if (gap_cnt == CNT_W'(STAGE_GAP - 1)) begin
            gap_cnt    <= '0;
            periph_n_q <= periph_n_q | rel_bit;
            periph_q   <= periph_q & ~rel_bit;
            if (idx == IDX_W'(NUM_PERIPH - 1)) begin
              done_q <= 1'b1;
              state  <= RUN;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= REL_PERIPH;
            end
          end else begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end

        RUN: begin
          periph_n_q <= ~sw_hold_nxt;
          periph_q   <= sw_hold_nxt;
        end

        default: state <= ASSERT;
      endcase
    end
  end

  assign rst_bus.interconnect_aresetn = ic_n_q;
  assign rst_bus.peripheral_aresetn   = periph_n_q;
  assign rst_bus.peripheral_reset     = periph_q;
  assign rst_bus.reset_done           = done_q;
  assign rst_bus.reset_count          = reset_count_q;

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// Directed bench for pl_reset_sequencer: expectations are queued with a
// target edge number when stimulus is applied and checked as edges occur.
module tb_pl_reset_sequencer;

  localparam int unsigned NP = 4;

  typedef struct {
    int          cyc;
    string       tag;
    logic [13:0] val;
  } exp_t;

  logic slowest_sync_clk = 1'b0;
  logic ext_reset_in;

  pl_reset_if #(.NUM_PERIPH(NP)) bus ();

  pl_reset_sequencer #(
    .NUM_PERIPH      (NP),
    .HOLD_CYCLES     (16),
    .STAGE_GAP       (8),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .slowest_sync_clk (slowest_sync_clk),
    .ext_reset_in     (ext_reset_in),
    .rst_bus          (bus.master)
  );

  always #5 slowest_sync_clk = ~slowest_sync_clk;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;

  // {interconnect_aresetn, peripheral_aresetn[3:0], reset_done, reset_count}
  function automatic logic [13:0] pk(input logic ic, input logic [3:0] pn,
                                     input logic d, input logic [7:0] c);
    return {ic, pn, d, c};
  endfunction

  task automatic push(input int rel, input string tag, input logic [13:0] v);
    exp_t e;
    e.cyc = cyc + rel;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  // Expected release timeline; edge 1 is the next edge
  task automatic push_release(input logic [7:0] c);
    push(15, "ic_hold",  pk(1'b0, 4'b0000, 1'b0, c));
    push(16, "ic_rel",   pk(1'b1, 4'b0000, 1'b0, c));
    push(23, "p0_pre",   pk(1'b1, 4'b0000, 1'b0, c));
    push(24, "p0_rel",   pk(1'b1, 4'b0001, 1'b0, c));
    push(31, "p1_pre",   pk(1'b1, 4'b0001, 1'b0, c));
    push(32, "p1_rel",   pk(1'b1, 4'b0011, 1'b0, c));
    push(40, "p2_rel",   pk(1'b1, 4'b0111, 1'b0, c));
    push(47, "p3_pre",   pk(1'b1, 4'b0111, 1'b0, c));
    push(48, "p3_done",  pk(1'b1, 4'b1111, 1'b1, c));
  endtask

  task automatic drain();
    exp_t        e;
    logic [13:0] obs;
    while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      e   = sbq.pop_front();
      obs = {bus.interconnect_aresetn, bus.peripheral_aresetn,
             bus.reset_done, bus.reset_count};
      checks++;
      assert (obs === e.val) begin
        passed++;
      end else begin
        $error("FAIL %s edge=%0d observed=%h expected=%h", e.tag, cyc, obs, e.val);
      end
      checks++;
      assert (bus.peripheral_reset === ~e.val[12:9]) begin
        passed++;
      end else begin
        $error("FAIL %s_inv edge=%0d observed=%b expected=%b", e.tag, cyc,
               bus.peripheral_reset, ~e.val[12:9]);
      end
    end
  endtask

  // Advance n edges, checking due expectations 1 time unit after each edge
  task automatic wait_neg(input int n);
    repeat (n) begin
      @(posedge slowest_sync_clk);
      #1;
      cyc++;
      drain();
      @(negedge slowest_sync_clk);
    end
  endtask

  initial begin
    ext_reset_in        = 1'b0;
    bus.aux_reset_in    = 1'b0;
    bus.periph_sw_reset = '0;

    // Power-on
    push(1, "por_reset", pk(1'b0, 4'b0000, 1'b0, 8'd0));
    wait_neg(7);
    ext_reset_in = 1'b1;
    push_release(8'd0);
    wait_neg(48);

    // Aux glitch of 3 cycles is filtered
    bus.aux_reset_in = 1'b1;
    push(3, "glitch_hold", pk(1'b1, 4'b1111, 1'b1, 8'd0));
    wait_neg(3);
    bus.aux_reset_in = 1'b0;
    push(1, "glitch_after", pk(1'b1, 4'b1111, 1'b1, 8'd0));
    wait_neg(2);

    // Aux of 4 cycles triggers a global reset
    bus.aux_reset_in = 1'b1;
    push(3, "aux_pre",  pk(1'b1, 4'b1111, 1'b1, 8'd0));
    push(4, "aux_trig", pk(1'b0, 4'b0000, 1'b0, 8'd1));
    wait_neg(4);
    bus.aux_reset_in = 1'b0;
    push_release(8'd1);
    wait_neg(48);

    // Single software reset pulse on channel 2
    bus.periph_sw_reset = 4'b0100;
    push(1,  "sw_assert",  pk(1'b1, 4'b1011, 1'b1, 8'd1));
    push(16, "sw_hold",    pk(1'b1, 4'b1011, 1'b1, 8'd1));
    push(17, "sw_release", pk(1'b1, 4'b1111, 1'b1, 8'd1));
    wait_neg(1);
    bus.periph_sw_reset = '0;
    wait_neg(19);

    // Second request 10 cycles in restarts the hold
    bus.periph_sw_reset = 4'b0100;
    push(1,  "sw2_assert",    pk(1'b1, 4'b1011, 1'b1, 8'd1));
    push(17, "sw2_restarted", pk(1'b1, 4'b1011, 1'b1, 8'd1));
    push(26, "sw2_hold",      pk(1'b1, 4'b1011, 1'b1, 8'd1));
    push(27, "sw2_release",   pk(1'b1, 4'b1111, 1'b1, 8'd1));
    wait_neg(1);
    bus.periph_sw_reset = '0;
    wait_neg(9);
    bus.periph_sw_reset = 4'b0100;
    wait_neg(1);
    bus.periph_sw_reset = '0;
    wait_neg(20);

    // Software requests during REL_PERIPH are ignored
    bus.aux_reset_in = 1'b1;
    push(4, "aux_trig2", pk(1'b0, 4'b0000, 1'b0, 8'd2));
    wait_neg(4);
    bus.aux_reset_in = 1'b0;
    push_release(8'd2);
    push(50, "no_extra_sw", pk(1'b1, 4'b1111, 1'b1, 8'd2));
    wait_neg(24);
    bus.periph_sw_reset = 4'b1111;
    wait_neg(20);
    bus.periph_sw_reset = '0;
    wait_neg(10);

    // ext_reset_in abort one cycle after peripheral 1 release
    bus.aux_reset_in = 1'b1;
    push(4, "aux_trig3", pk(1'b0, 4'b0000, 1'b0, 8'd3));
    wait_neg(4);
    bus.aux_reset_in = 1'b0;
    push(16, "ab_ic",         pk(1'b1, 4'b0000, 1'b0, 8'd3));
    push(24, "ab_p0",         pk(1'b1, 4'b0001, 1'b0, 8'd3));
    push(32, "ab_p1",         pk(1'b1, 4'b0011, 1'b0, 8'd3));
    push(33, "ab_reasserted", pk(1'b0, 4'b0000, 1'b0, 8'd0));
    wait_neg(32);
    ext_reset_in = 1'b0;
    wait_neg(1);
    ext_reset_in = 1'b1;
    push_release(8'd0);
    wait_neg(48);

    // 256 aux triggers saturate the counter
    for (int i = 0; i < 256; i++) begin
      bus.aux_reset_in = 1'b1;
      if (i == 0)   push(4, "sat_first", pk(1'b0, 4'b0000, 1'b0, 8'd1));
      if (i == 254) push(4, "sat_255",   pk(1'b0, 4'b0000, 1'b0, 8'd255));
      if (i == 255) push(4, "sat_hold",  pk(1'b0, 4'b0000, 1'b0, 8'd255));
      wait_neg(4);
      bus.aux_reset_in = 1'b0;
      wait_neg(16);
    end
    push(32, "sat_run", pk(1'b1, 4'b1111, 1'b1, 8'd255));
    wait_neg(32);

    // Aux trigger and software request on the same edge: global reset wins
    bus.aux_reset_in = 1'b1;
    wait_neg(3);
    bus.periph_sw_reset = 4'b0001;
    push(1, "prio_aux_wins", pk(1'b0, 4'b0000, 1'b0, 8'd255));
    wait_neg(1);
    bus.aux_reset_in    = 1'b0;
    bus.periph_sw_reset = '0;
    push_release(8'd255);
    wait_neg(48);

    for (int k = 0; k < 5 && sbq.size() != 0; k++) wait_neg(1);
    checks++;
    assert (sbq.size() == 0) begin
      passed++;
    end else begin
      $error("FAIL scoreboard_drain observed=%0d pending expected=0", sbq.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pl_reset_sequencer.md
Name: pl_reset_sequencer

Overview:
- Staged PL reset controller for all resets driven from the slowest_sync_clk domain.
- Releases the interconnect reset first, then releases peripherals one at a time at a fixed spacing.
- Accepts a debounced auxiliary (debug/watchdog) global reset request.
- Provides per-peripheral software reset pulses with a guaranteed minimum hold time.

Parameters:
- NUM_PERIPH, 4: number of peripheral reset channels (1..8).
- HOLD_CYCLES, 16: minimum reset assertion length in cycles, used for global and software resets (2..255).
- STAGE_GAP, 8: cycles between successive reset releases (1..255).
- DEBOUNCE_CYCLES, 4: consecutive high samples of aux_reset_in needed to trigger a reset (1..15).

Ports:
- slowest_sync_clk  in  1  sole clock; all logic on rising edge.
- ext_reset_in  in  1  synchronous, active-low block reset. Sampled on slowest_sync_clk.
- aux_reset_in  in  1  active-high global reset request, already synchronous to the clock; must be debounced.
- periph_sw_reset  in  NUM_PERIPH  per-channel software reset request; level sampled each cycle.
- interconnect_aresetn  out  1  active-low interconnect reset.
- peripheral_aresetn  out  NUM_PERIPH  active-low peripheral resets.
- peripheral_reset  out  NUM_PERIPH  active-high peripheral resets; always the bitwise inverse of peripheral_aresetn.
- reset_done  out  1  high once every reset output is released after a global reset.
- reset_count  out  8  count of aux-triggered global resets; saturates at 255.

Behaviour:
- All outputs are registered.
- ext_reset_in=0 at any edge forces the following, overriding everything else:
  - state=ASSERT, all counters=0;
  - interconnect_aresetn=0, peripheral_aresetn=0, peripheral_reset=all 1s;
  - reset_done=0, reset_count=0.
- States: ASSERT -> REL_IC -> REL_PERIPH -> RUN.
- ASSERT:
  - hold counter increments each edge while ext_reset_in=1 and aux_reset_in=0;
  - aux_reset_in=1 clears the hold counter, which extends the hold;
  - at count HOLD_CYCLES-1, go to REL_IC and set interconnect_aresetn=1 on that edge.
  - Net effect: interconnect_aresetn rises on the HOLD_CYCLES-th edge counting the first edge that samples ext_reset_in=1 as edge 1.
- REL_IC / REL_PERIPH:
  - every STAGE_GAP edges, release the next peripheral in order 0,1,...,NUM_PERIPH-1;
  - peripheral i rises STAGE_GAP*(i+1) edges after interconnect_aresetn rises;
  - reset_done=1 on the same edge as the last peripheral release, then go to RUN.
- Aux trigger:
  - in any state except ASSERT, aux_reset_in=1 for DEBOUNCE_CYCLES consecutive edges triggers a global reset;
  - on the final sampling edge: go to ASSERT, assert all resets, reset_done=0, reset_count+1 (saturating), counters cleared;
  - any low sample clears the debounce counter;
  - the debounce counter is held at 0 while in ASSERT.
- Software reset:
  - applies in RUN only; periph_sw_reset[i]=1 sampled at an edge sets peripheral_aresetn[i]=0 on that edge;
  - the reset is held HOLD_CYCLES edges, then released;
  - a request seen during the hold restarts the hold count;
  - requests in any other state are ignored;
  - reset_done and interconnect_aresetn are unaffected.
- Simultaneous events:
  - aux trigger beats software reset; all per-channel holds clear.
  - Multiple software requests on the same edge are serviced independently.
- Reset mid-sequence: ext_reset_in=0 or an aux trigger in REL_IC or REL_PERIPH re-asserts everything and restarts from ASSERT.

Decomposition:
- Package pl_reset_pkg:
  - state enum (ASSERT, REL_IC, REL_PERIPH, RUN);
  - default parameter constants;
  - counter width constant of 8 bits.
- Sub-module pl_reset_hold_timer, one instance per channel:
  - inputs: start, clear, HOLD_CYCLES;
  - output: active.

Test Plan:
- Power-on sequencing: ext_reset_in=0 for 7 cycles, then 1 (defaults) -> interconnect_aresetn rises at edge 16, peripheral_aresetn[0..3] rise at edges 24/32/40/48, reset_done=1 at edge 48, reset_count=0.
- Aux glitch: in RUN, aux_reset_in high for 3 cycles -> no change. Then high for 4 cycles -> all resets asserted on edge 4, reset_count=1, re-release follows the 16/24/32/40/48 timing from the first edge after aux_reset_in goes low.
- Software reset: in RUN, periph_sw_reset[2]=1 for 1 cycle -> peripheral_aresetn[2] low for 16 edges, peripheral_reset[2] mirrors it, other channels and reset_done stay high. A second pulse 10 cycles in -> total low time 26 edges.
- Request outside RUN: periph_sw_reset=4'b1111 held during REL_PERIPH and then dropped before RUN -> no extra resets, release timing unchanged.
- Mid-sequence abort: ext_reset_in=0 one cycle after peripheral 1 is released -> all outputs re-asserted on that edge, full sequence restarts.
- Saturation and priority: 256 aux triggers -> reset_count=255. Aux trigger on the same edge as periph_sw_reset[0] -> global reset wins, channel 0 hold cleared.
